// File: rtl/dpram_pkg.sv
// ----------------------------------------------------------------------------
// dpram_pkg
// Shared constants and types for the dual-port-RAM FIFO controller slice.
//
// Contents:
//   DW, AW, DEPTH : default data width, address width and entry count
//   data_t        : one RAM word
//   addr_t        : one RAM address / FIFO pointer
//   count_t       : occupancy count, one bit wider than an address so that
//                   a completely full FIFO (DEPTH words) is representable
// ----------------------------------------------------------------------------
package dpram_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   count_t;

endpackage : dpram_pkg

// File: rtl/dpram_fifo_ptr.sv
// ----------------------------------------------------------------------------
// dpram_fifo_ptr
// Wrapping RAM address pointer. Advances by one on every clock edge where
// 'en' is high; the natural overflow of the PW-bit register gives the
// modulo-DEPTH wrap (DEPTH == 2**PW).
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; returns the pointer to 0
//   en    : advance the pointer this cycle
//   ptr   : current pointer value
// ----------------------------------------------------------------------------
module dpram_fifo_ptr
    import dpram_pkg::*;
#(
    parameter int PW = AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule : dpram_fifo_ptr

// File: rtl/dpram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// dpram_fifo_ctrl
// FIFO controller that masters an external dual-port RAM (no storage inside).
// The write stream is pushed straight into the RAM; words are fetched from
// the RAM one cycle ahead and presented on the read stream directly from the
// RAM's registered read data.
//
// Optional feature (compile-time macro DPRAM_FIFO_CTRL_ERR_EN):
//   adds ovf_err (sticky overflow flag) and err_clr (flag clear) ports.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low
//   s_valid      : write-stream word valid
//   s_ready      : controller can accept a word (low when full or in reset)
//   s_data       : write-stream word
//   m_valid      : read-stream word valid
//   m_ready      : consumer takes the presented word
//   m_data       : read-stream word (= ram_data_out)
//   count        : words held, RAM-resident plus the presented word
//   full, empty  : count == DEPTH / count == 0
//   ram_wr_en    : RAM write strobe
//   ram_wr_addr  : RAM write address
//   ram_data_in  : RAM write data
//   ram_rd_en    : RAM read strobe
//   ram_rd_addr  : RAM read address
//   ram_data_out : RAM registered read data (1-cycle latency, holds otherwise)
//   ovf_err      : [macro] set by a write attempt while full, sticky
//   err_clr      : [macro] clears ovf_err (a new overflow in the same cycle wins)
// ----------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int DW    = dpram_pkg::DW,
    parameter int AW    = dpram_pkg::AW,
    parameter int DEPTH = dpram_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_data_out
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    ,
    output logic          ovf_err,
    input  logic          err_clr
`endif
);

    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   stored;
    logic          push;
    logic          rd_fire;

    // Occupancy seen by the outside world includes the word already fetched
    // and sitting on m_data, so 'full' blocks writes even when the RAM itself
    // still has a free slot behind a stalled output word.
    assign count = stored + {{AW{1'b0}}, m_valid};
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Writes are refused during reset as well as when full; there is no
    // bypass, so a pop in the same cycle as full does not open the door.
    assign s_ready     = reset && !full;
    assign push        = s_valid && s_ready;
    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr;
    assign ram_data_in = s_data;

    // Fetch the next RAM word whenever the output slot is free or is being
    // emptied this cycle; this keeps one word per cycle flowing with no
    // bubbles while the consumer is ready. A stalled output word blocks the
    // fetch, which keeps ram_data_out (and hence m_data) frozen.
    assign rd_fire     = (stored != '0) && (!m_valid || m_ready);
    assign ram_rd_en   = rd_fire;
    assign ram_rd_addr = rd_ptr;
    assign m_data      = ram_data_out;

    dpram_fifo_ptr #(
        .PW    (AW)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (push),
        .ptr   (wr_ptr)
    );

    dpram_fifo_ptr #(
        .PW    (AW)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (rd_fire),
        .ptr   (rd_ptr)
    );

    // Words written to the RAM but not yet fetched out of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stored <= '0;
        end else begin
            case ({push, rd_fire})
                2'b10:   stored <= stored + 1'b1;
                2'b01:   stored <= stored - 1'b1;
                default: stored <= stored;
            endcase
        end
    end

    // The RAM read data arrives one cycle after the fetch, so m_valid is the
    // fetch strobe delayed by one; it falls only when the presented word is
    // taken and nothing new was fetched behind it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
        end else if (rd_fire) begin
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef DPRAM_FIFO_CTRL_ERR_EN
    // Sticky overflow flag: any write attempt while full sets it, and a new
    // overflow takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_err <= 1'b0;
        end else if (s_valid && full) begin
            ovf_err <= 1'b1;
        end else if (err_clr) begin
            ovf_err <= 1'b0;
        end
    end
`endif

endmodule : dpram_fifo_ctrl

// File: tb/tb_dpram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dpram_fifo_ctrl
// Directed self-checking bench for dpram_fifo_ctrl. A small behavioural
// dual-port RAM (registered read, holds when not read) is attached to the
// controller's RAM ports. Each scenario task drives its own vectors and
// compares against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further unit later, well before the next edge.
// Build with DPRAM_FIFO_CTRL_ERR_EN defined to include the overflow checks.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dpram_fifo_ctrl;
    import dpram_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   s_valid;
    logic   s_ready;
    data_t  s_data;
    logic   m_valid;
    logic   m_ready;
    data_t  m_data;
    count_t count;
    logic   full;
    logic   empty;
    logic   ram_wr_en;
    addr_t  ram_wr_addr;
    data_t  ram_data_in;
    logic   ram_rd_en;
    addr_t  ram_rd_addr;
    data_t  ram_data_out;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    logic   ovf_err;
    logic   err_clr;
`endif

    int checks   = 0;
    int failures = 0;

    data_t mem [DEPTH];

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(
        .DW           (DW),
        .AW           (AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_data_in  (ram_data_in),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_data_out (ram_data_out)
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        ,
        .ovf_err      (ovf_err),
        .err_clr      (err_clr)
`endif
    );

    // External dual-port RAM model.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
        if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        m_ready = 1'b1;
        tick();
        #1;
        checks++; if (s_ready !== 1'b0)   begin failures++; $display("[TB] FAIL rst_s_ready: got %b want 0", s_ready); end
        checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_en: got %b want 0", ram_wr_en); end
        checks++; if (ram_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_rd_en: got %b want 0", ram_rd_en); end
        checks++; if (count !== 5'd0)     begin failures++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1)     begin failures++; $display("[TB] FAIL rst_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0)      begin failures++; $display("[TB] FAIL rst_full: got %b want 0", full); end
        checks++; if (m_valid !== 1'b0)   begin failures++; $display("[TB] FAIL rst_m_valid: got %b want 0", m_valid); end
        tick();
        #1;
        checks++; if (count !== 5'd0)     begin failures++; $display("[TB] FAIL rst_hold_count: got %0d want 0", count); end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h11;
        #1;
        checks++; if (ram_wr_en !== 1'b1)   begin failures++; $display("[TB] FAIL lat_wr_en: got %b want 1", ram_wr_en); end
        checks++; if (ram_wr_addr !== 4'd0) begin failures++; $display("[TB] FAIL lat_wr_addr: got %0d want 0", ram_wr_addr); end
        checks++; if (ram_data_in !== 8'h11) begin failures++; $display("[TB] FAIL lat_wr_data: got %h want 11", ram_data_in); end
        checks++; if (ram_rd_en !== 1'b0)   begin failures++; $display("[TB] FAIL lat_rd_early: got %b want 0", ram_rd_en); end
        tick();
        s_valid = 1'b0;
        #1;
        checks++; if (ram_rd_en !== 1'b1)   begin failures++; $display("[TB] FAIL lat_rd_en: got %b want 1", ram_rd_en); end
        checks++; if (ram_rd_addr !== 4'd0) begin failures++; $display("[TB] FAIL lat_rd_addr: got %0d want 0", ram_rd_addr); end
        checks++; if (m_valid !== 1'b0)     begin failures++; $display("[TB] FAIL lat_m_valid_t1: got %b want 0", m_valid); end
        checks++; if (count !== 5'd1)       begin failures++; $display("[TB] FAIL lat_count_t1: got %0d want 1", count); end
        tick();
        #1;
        checks++; if (m_valid !== 1'b1)     begin failures++; $display("[TB] FAIL lat_m_valid_t2: got %b want 1", m_valid); end
        checks++; if (m_data !== 8'h11)     begin failures++; $display("[TB] FAIL lat_m_data: got %h want 11", m_data); end
        checks++; if (count !== 5'd1)       begin failures++; $display("[TB] FAIL lat_count_t2: got %0d want 1", count); end
        checks++; if (ram_rd_en !== 1'b0)   begin failures++; $display("[TB] FAIL lat_rd_idle: got %b want 0", ram_rd_en); end
        m_ready = 1'b1;
        tick();
        #1;
        checks++; if (m_valid !== 1'b0)     begin failures++; $display("[TB] FAIL lat_pop_valid: got %b want 0", m_valid); end
        checks++; if (empty !== 1'b1)       begin failures++; $display("[TB] FAIL lat_pop_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h20 + i);
            #1;
            checks++;
            if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'(i)) begin
                failures++;
                $display("[TB] FAIL fill_wr[%0d]: got en=%b addr=%0d want en=1 addr=%0d", i, ram_wr_en, ram_wr_addr, i);
            end
            tick();
        end
        s_valid = 1'b1;
        s_data  = 8'hFF;
        #1;
        checks++; if (full !== 1'b1)      begin failures++; $display("[TB] FAIL full_flag: got %b want 1", full); end
        checks++; if (count !== 5'd16)    begin failures++; $display("[TB] FAIL full_count: got %0d want 16", count); end
        checks++; if (s_ready !== 1'b0)   begin failures++; $display("[TB] FAIL full_s_ready: got %b want 0", s_ready); end
        checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL full_wr_en: got %b want 0", ram_wr_en); end
        checks++; if (empty !== 1'b0)     begin failures++; $display("[TB] FAIL full_empty: got %b want 0", empty); end
        m_ready = 1'b1;
        #1;
        checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL full_no_bypass: got %b want 0", ram_wr_en); end
        checks++; if (m_data !== 8'h20)   begin failures++; $display("[TB] FAIL full_head: got %h want 20", m_data); end
        tick();
        s_valid = 1'b0;
        #1;
        checks++; if (count !== 5'd15)    begin failures++; $display("[TB] FAIL full_pop_count: got %0d want 15", count); end
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(8'h20 + i)) begin
                failures++;
                $display("[TB] FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, 8'(8'h20 + i));
            end
            tick();
            #1;
        end
        checks++; if (empty !== 1'b1)     begin failures++; $display("[TB] FAIL drain_empty: got %b want 1", empty); end
        checks++; if (m_valid !== 1'b0)   begin failures++; $display("[TB] FAIL drain_m_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 67; cyc++) begin
            s_valid = (cyc < 64);
            s_data  = 8'(cyc);
            #1;
            if (cyc < 64) begin
                checks++;
                if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'(cyc)) begin
                    failures++;
                    $display("[TB] FAIL stream_wr[%0d]: got en=%b addr=%0d want en=1 addr=%0d", cyc, ram_wr_en, ram_wr_addr, cyc % 16);
                end
            end
            if (cyc >= 1 && cyc < 65) begin
                checks++;
                if (ram_rd_en !== 1'b1 || ram_rd_addr !== 4'(cyc - 1)) begin
                    failures++;
                    $display("[TB] FAIL stream_rd[%0d]: got en=%b addr=%0d want en=1 addr=%0d", cyc, ram_rd_en, ram_rd_addr, (cyc - 1) % 16);
                end
            end
            if (cyc >= 2 && cyc < 66) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'(cyc - 2)) begin
                    failures++;
                    $display("[TB] FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", cyc, m_valid, m_data, 8'(cyc - 2));
                end
            end
            if (cyc >= 2 && cyc < 64) begin
                checks++;
                if (count !== 5'd2) begin
                    failures++;
                    $display("[TB] FAIL stream_count[%0d]: got %0d want 2", cyc, count);
                end
            end
            tick();
        end
        #1;
        checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL stream_empty: got %b want 1", empty); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_m_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        int          pushed;
        int          popped;
        logic        stalled;
        pat     = 16'b1011_0010_0111_0100;
        pushed  = 0;
        popped  = 0;
        stalled = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
            s_valid = (pushed < 20);
            s_data  = 8'(8'h40 + pushed);
            m_ready = pat[cyc % 16];
            #1;
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", cyc, m_valid);
                end
            end
            if (m_valid === 1'b1) begin
                checks++;
                if (m_data !== 8'(8'h40 + popped)) begin
                    failures++;
                    $display("[TB] FAIL bp_data[%0d]: got %h want %h", cyc, m_data, 8'(8'h40 + popped));
                end
                if (m_ready) popped++;
            end
            stalled = (m_valid === 1'b1) && !m_ready;
            if (s_valid && s_ready) pushed++;
            tick();
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++; if (popped != 20)   begin failures++; $display("[TB] FAIL bp_popped: got %0d want 20", popped); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL bp_empty: got %b want 1", empty); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h60 + i);
            tick();
        end
        s_valid = 1'b0;
        #1;
        checks++; if (count !== 5'd7)   begin failures++; $display("[TB] FAIL mr_count_before: got %0d want 7", count); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (count !== 5'd0)   begin failures++; $display("[TB] FAIL mr_count_async: got %0d want 0", count); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL mr_m_valid_async: got %b want 0", m_valid); end
        checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL mr_empty_async: got %b want 1", empty); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL mr_s_ready_async: got %b want 0", s_ready); end
        tick();
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        #1;
        checks++;
        if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd0) begin
            failures++;
            $display("[TB] FAIL mr_wr: got en=%b addr=%0d want en=1 addr=0", ram_wr_en, ram_wr_addr);
        end
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL mr_first_out: got v=%b d=%h want v=1 d=a5", m_valid, m_data);
        end
        tick();
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL mr_no_stale: got %b want 0", m_valid); end
        checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL mr_empty_after: got %b want 1", empty); end
    endtask

`ifdef DPRAM_FIFO_CTRL_ERR_EN
    task automatic test_overflow();
        do_reset();
        #1;
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("[TB] FAIL ovf_reset: got %b want 0", ovf_err); end
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h80 + i);
            tick();
        end
        #1;
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("[TB] FAIL ovf_not_yet: got %b want 0", ovf_err); end
        tick();
        s_valid = 1'b0;
        #1;
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b want 1", ovf_err); end
        tick();
        #1;
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear: got %b want 0", ovf_err); end
        s_valid = 1'b1;
        err_clr = 1'b1;
        tick();
        s_valid = 1'b0;
        err_clr = 1'b0;
        #1;
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set_wins: got %b want 1", ovf_err); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_latency();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dpram_fifo_ctrl
